// File: rtl/prog_down_counter.sv
// Loadable down-counter/timer with prescaler, one-shot or auto-reload mode,
// hold and abort. oflag pulses for one cycle when the count expires.
module prog_down_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      din,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  reload_en,
  input  logic                  hold,
  input  logic                  abort,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  oflag
);

  // state | meaning
  // IDLE  | no countdown active; count parked at its last value (0)
  // RUN   | counting down; prescaler advances unless hold is high
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      count_r, count_nxt;
  logic [WIDTH-1:0]      reload_r, reload_nxt;
  logic [PRESCALE_W-1:0] psc_cnt, psc_cnt_nxt;
  logic [PRESCALE_W-1:0] psc_lat, psc_lat_nxt;
  logic                  mode_r, mode_nxt;
  logic                  oflag_r, oflag_nxt;

  logic kill, load, advance, tick, expire;

  // A zero-length load has nothing to count, so it behaves like abort.
  assign kill    = abort || (ena && (din == '0));
  assign load    = ena && (din != '0) && !abort;
  assign advance = (state == RUN) && !hold && !kill && !load;
  assign tick    = advance && (psc_cnt == psc_lat);
  assign expire  = tick && (count_r == WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_r  <= '0;
      reload_r <= '0;
      psc_cnt  <= '0;
      psc_lat  <= '0;
      mode_r   <= 1'b0;
      oflag_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_r  <= count_nxt;
      reload_r <= reload_nxt;
      psc_cnt  <= psc_cnt_nxt;
      psc_lat  <= psc_lat_nxt;
      mode_r   <= mode_nxt;
      oflag_r  <= oflag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (kill)
      state_nxt = IDLE;
    else if (load)
      state_nxt = RUN;
    else if (expire && !mode_r)
      state_nxt = IDLE;
  end

  always_comb begin
    count_nxt   = count_r;
    reload_nxt  = reload_r;
    psc_cnt_nxt = psc_cnt;
    psc_lat_nxt = psc_lat;
    mode_nxt    = mode_r;
    oflag_nxt   = 1'b0;
    if (kill) begin
      count_nxt   = '0;
      psc_cnt_nxt = '0;
    end else if (load) begin
      count_nxt   = din;
      reload_nxt  = din;
      psc_lat_nxt = prescale;
      mode_nxt    = reload_en;
      psc_cnt_nxt = '0;
    end else if (advance) begin
      if (tick) begin
        psc_cnt_nxt = '0;
        if (expire) begin
          oflag_nxt = 1'b1;
          count_nxt = mode_r ? reload_r : '0;
        end else begin
          count_nxt = count_r - WIDTH'(1);
        end
      end else begin
        psc_cnt_nxt = psc_cnt + PRESCALE_W'(1);
      end
    end
  end

  assign count = count_r;
  assign busy  = (state == RUN);
  assign oflag = oflag_r;

endmodule
